// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB serial data encoder.
// Holds the FSM state encoding and the default timing parameters used by rgb_data.
package rgb_pkg;

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StSend = 2'd1,
        StEnd  = 2'd2
    } rgb_state_e;

    localparam int unsigned PhasesPerBitDef = 4;
    localparam int unsigned HighOneDef      = 3;
    localparam int unsigned HighZeroDef     = 1;
    localparam int unsigned EndPhasesDef    = 2;

endpackage

// File: rtl/rgb_tick_detect.sv
// Phase-advance tick detector.
// Registers the toggle input every clock; any difference between the live input and its
// registered copy is one tick.
//   clk   : system clock
//   reset : synchronous active-low reset
//   in    : toggle input
//   tick  : combinational, high for one clock after each input change
module rgb_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic tick
);

    logic nf_q;

    // During reset the copy tracks the input, so releasing reset never produces a tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nf_q <= in;
        end else begin
            nf_q <= in;
        end
    end

    assign tick = in ^ nf_q;

endmodule

// File: rtl/rgb_data.sv
// RGB serial data encoder.
// Each byte takes one LOAD tick, 8 bits of PHASES_PER_BIT ticks (MSB first, pulse-width coded)
// and END_PHASES ticks of END, back to back.
//   clk      : system clock
//   reset    : synchronous active-low reset
//   nextflag : phase-advance toggle, every change is one tick
//   data     : byte to send, sampled only on the LOAD tick
//   endevent : registered, high while in END
//   outstat  : registered serial line output
module rgb_data
    import rgb_pkg::*;
#(
    parameter int unsigned PHASES_PER_BIT = PhasesPerBitDef,
    parameter int unsigned HIGH_ONE       = HighOneDef,
    parameter int unsigned HIGH_ZERO      = HighZeroDef,
    parameter int unsigned END_PHASES     = EndPhasesDef
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nextflag,
    input  logic [7:0] data,
    output logic       endevent,
    output logic       outstat
);

    localparam int unsigned PhaseW = (PHASES_PER_BIT > 1) ? $clog2(PHASES_PER_BIT) : 1;
    localparam int unsigned EndW   = $clog2(END_PHASES + 1);

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(PHASES_PER_BIT - 1);
    localparam logic [PhaseW-1:0] HighOneC  = PhaseW'(HIGH_ONE);
    localparam logic [PhaseW-1:0] HighZeroC = PhaseW'(HIGH_ZERO);
    localparam logic [EndW-1:0]   EndLast   = EndW'(END_PHASES - 1);

    logic tick;

    rgb_tick_detect u_tick_detect (
        .clk   (clk),
        .reset (reset),
        .in    (nextflag),
        .tick  (tick)
    );

    rgb_state_e        state_q, state_d;
    logic [7:0]        sr_q, sr_d;
    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [EndW-1:0]   end_cnt_q, end_cnt_d;
    logic              outstat_q, outstat_d;
    logic              endevent_q, endevent_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StLoad;
            sr_q        <= '0;
            phase_cnt_q <= '0;
            bit_cnt_q   <= '0;
            end_cnt_q   <= '0;
            outstat_q   <= 1'b0;
            endevent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            end_cnt_q   <= end_cnt_d;
            outstat_q   <= outstat_d;
            endevent_q  <= endevent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        phase_cnt_d = phase_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        end_cnt_d   = end_cnt_q;
        outstat_d   = outstat_q;
        endevent_d  = endevent_q;

        // Everything only moves on a tick; otherwise the whole block is frozen.
        if (tick) begin
            unique case (state_q)
                StLoad: begin
                    sr_d        = data;
                    phase_cnt_d = '0;
                    bit_cnt_d   = 3'd7;
                    outstat_d   = 1'b0;
                    state_d     = StSend;
                end
                StSend: begin
                    outstat_d = (phase_cnt_q < (sr_q[7] ? HighOneC : HighZeroC));
                    if (phase_cnt_q == PhaseLast) begin
                        phase_cnt_d = '0;
                        sr_d        = {sr_q[6:0], 1'b0};
                        if (bit_cnt_q == 3'd0) begin
                            // Last phase of the last bit: END starts on this same tick.
                            state_d    = StEnd;
                            endevent_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else begin
                        phase_cnt_d = phase_cnt_q + PhaseW'(1);
                    end
                end
                StEnd: begin
                    outstat_d = 1'b0;
                    if (end_cnt_q == EndLast) begin
                        end_cnt_d  = '0;
                        endevent_d = 1'b0;
                        state_d    = StLoad;
                    end else begin
                        end_cnt_d = end_cnt_q + EndW'(1);
                    end
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    assign outstat  = outstat_q;
    assign endevent = endevent_q;

endmodule

// File: tb/tb_rgb_data.sv
module tb_rgb_data;

    logic       clk;
    logic       reset;
    logic       nextflag;
    logic [7:0] data;
    logic       endevent;
    logic       outstat;

    int checks = 0;
    int errors = 0;

    rgb_data dut (
        .clk      (clk),
        .reset    (reset),
        .nextflag (nextflag),
        .data     (data),
        .endevent (endevent),
        .outstat  (outstat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock; optionally toggle nextflag first. Returns #1 after the edge.
    task automatic cyc(input bit tog);
        if (tog) nextflag = ~nextflag;
        @(posedge clk);
        #1;
    endtask

    // Tick idx after the LOAD tick (1..34); pat holds the 32 expected SEND bits, first in MSB.
    task automatic do_tick(input logic [31:0] pat, input int idx);
        string tag;
        cyc(1'b1);
        tag = $sformatf("tick%0d", idx);
        if (idx <= 32) begin
            chk({tag, "_out"}, outstat, pat[32-idx]);
            chk({tag, "_end"}, endevent, (idx == 32));
        end else begin
            chk({tag, "_out"}, outstat, 1'b0);
            chk({tag, "_end"}, endevent, (idx == 33));
        end
    endtask

    task automatic load_tick();
        cyc(1'b1);
        chk("load_out", outstat, 1'b0);
        chk("load_end", endevent, 1'b0);
    endtask

    // Full byte: data changes mid-SEND must not matter; next byte's data goes in at endevent.
    task automatic send_byte(input logic [31:0] pat, input logic [7:0] mid_data,
                             input logic [7:0] next_data);
        load_tick();
        for (int i = 1; i <= 34; i++) begin
            do_tick(pat, i);
            if (i == 10) data = mid_data;
            if (i == 32) data = next_data;
        end
    endtask

    initial begin
        reset    = 1'b0;
        nextflag = 1'b0;
        data     = 8'hFF;

        // Reset with nextflag toggling: nothing may move.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            chk("rst_out", outstat, 1'b0);
            chk("rst_end", endevent, 1'b0);
        end
        reset = 1'b1;
        cyc(1'b0);
        chk("rel_out", outstat, 1'b0);
        chk("rel_end", endevent, 1'b0);

        // Back-to-back bytes FF, 00, 01, A5 with data updated at each endevent.
        send_byte(32'hEEEEEEEE, 8'h12, 8'h00);
        send_byte(32'h88888888, 8'h77, 8'h01);
        send_byte(32'h8888888E, 8'h55, 8'hA5);
        send_byte(32'hE8E88E8E, 8'h00, 8'hA5);

        // Stall mid-bit for 10 clocks, then resume.
        load_tick();
        for (int i = 1; i <= 5; i++) do_tick(32'hE8E88E8E, i);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            chk("hold_out", outstat, 1'b1);
            chk("hold_end", endevent, 1'b0);
        end
        for (int i = 6; i <= 34; i++) do_tick(32'hE8E88E8E, i);

        // Reset during bit 3 (ticks 17..20) while outstat is high, tick in the same clock.
        load_tick();
        for (int i = 1; i <= 17; i++) do_tick(32'hE8E88E8E, i);
        reset = 1'b0;
        cyc(1'b1);
        chk("midsend_rst_out", outstat, 1'b0);
        chk("midsend_rst_end", endevent, 1'b0);
        reset = 1'b1;
        data  = 8'h00;
        cyc(1'b0);
        chk("midsend_rel_out", outstat, 1'b0);

        // Next tick is LOAD with fresh data; abort this one in END.
        load_tick();
        for (int i = 1; i <= 33; i++) do_tick(32'h88888888, i);
        reset = 1'b0;
        cyc(1'b0);
        chk("midend_rst_out", outstat, 1'b0);
        chk("midend_rst_end", endevent, 1'b0);
        reset = 1'b1;
        data  = 8'h3C;
        cyc(1'b0);
        chk("midend_rel_end", endevent, 1'b0);
        send_byte(32'h88EEEE88, 8'hFF, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
